// File: rtl/mole_pkg.sv
// Shared constants and one-hot helpers for the whack-a-mole keypad front end.
package mole_pkg;

    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned NUM_KEYS = 16;
    localparam int unsigned KEY_W    = 4;

    // Index of the highest set bit; callers only use it on one-hot vectors.
    function automatic logic [KEY_W-1:0] onehot_index(input logic [NUM_KEYS-1:0] vec);
        logic [KEY_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (vec[i]) begin
                idx = i[KEY_W-1:0];
            end
        end
        return idx;
    endfunction

    function automatic logic is_onehot(input logic [NUM_KEYS-1:0] vec);
        return (vec != '0) && ((vec & (vec - 16'd1)) == '0);
    endfunction

endpackage

// File: rtl/mole_keypad_scanner_if.sv
// Keypad matrix pins plus the decoded hit outputs consumed by the Mole top.
interface mole_keypad_scanner_if;
    import mole_pkg::*;

    logic                Enable;
    logic [NUM_COLS-1:0] Col;
    logic [NUM_ROWS-1:0] Row;
    logic [NUM_KEYS-1:0] Hit_point;
    logic                Key_valid;
    logic [KEY_W-1:0]    Key_code;

    modport master (
        input  Enable,
        input  Row,
        output Col,
        output Hit_point,
        output Key_valid,
        output Key_code
    );

    modport slave (
        output Enable,
        output Row,
        input  Col,
        input  Hit_point,
        input  Key_valid,
        input  Key_code
    );

endinterface

// File: rtl/mole_row_sync.sv
// Two-flop synchroniser for the asynchronous, active-low row sense lines.
module mole_row_sync
    import mole_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_ROWS-1:0] din,
    output logic [NUM_ROWS-1:0] dout
);

    logic [NUM_ROWS-1:0] meta_q;
    logic [NUM_ROWS-1:0] sync_q;

    // Clears to all-high, i.e. "no key pressed".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
        end
    end

    assign dout = sync_q;

endmodule

// File: rtl/mole_keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, frame debounce and single-key press pulse.
module mole_keypad_scanner
    import mole_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 4,
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic                   Clk,
    input  logic                   Set,
    mole_keypad_scanner_if.master  kp
);

    localparam logic [7:0] DWELL_LAST = 8'(SCAN_DIV - 1);
    localparam logic [3:0] STABLE_MAX = 4'(DEBOUNCE);

    logic [NUM_ROWS-1:0] row_s;

    logic [1:0]          col_q,            col_d;
    logic [7:0]          dwell_q,          dwell_d;
    logic [NUM_KEYS-1:0] frame_q,          frame_d;
    logic [NUM_KEYS-1:0] prev_frame_q,     prev_frame_d;
    logic [NUM_KEYS-1:0] debounced_q,      debounced_d;
    logic [NUM_KEYS-1:0] debounced_prev_q;
    logic [3:0]          stable_q,         stable_d;
    logic [KEY_W-1:0]    key_code_q;

    logic                sample;
    logic                frame_end;
    logic [NUM_KEYS-1:0] rise;
    logic                fire;

    mole_row_sync u_row_sync (
        .clk   (Clk),
        .rst_n (Set),
        .din   (kp.Row),
        .dout  (row_s)
    );

    assign sample    = (dwell_q == DWELL_LAST);
    assign frame_end = sample && (col_q == 2'd3);

    always_comb begin
        col_d        = col_q;
        dwell_d      = dwell_q + 8'd1;
        frame_d      = frame_q;
        prev_frame_d = prev_frame_q;
        debounced_d  = debounced_q;
        stable_d     = stable_q;

        if (sample) begin
            dwell_d = '0;
            col_d   = col_q + 2'd1;
            for (int r = 0; r < NUM_ROWS; r++) begin
                frame_d[r*NUM_COLS + int'(col_q)] = ~row_s[r];
            end
        end

        // Debounce compares the frame including the column sampled this cycle.
        if (frame_end) begin
            prev_frame_d = frame_d;
            if (frame_d == prev_frame_q) begin
                stable_d = (stable_q >= STABLE_MAX) ? STABLE_MAX : stable_q + 4'd1;
            end else begin
                stable_d = 4'd1;
            end
            if (stable_d == STABLE_MAX) begin
                debounced_d = frame_d;
            end
        end
    end

    always_ff @(posedge Clk or negedge Set) begin
        if (!Set) begin
            col_q            <= '0;
            dwell_q          <= '0;
            frame_q          <= '0;
            prev_frame_q     <= '0;
            debounced_q      <= '0;
            debounced_prev_q <= '0;
            stable_q         <= '0;
            key_code_q       <= '0;
        end else begin
            col_q            <= col_d;
            dwell_q          <= dwell_d;
            frame_q          <= frame_d;
            prev_frame_q     <= prev_frame_d;
            debounced_q      <= debounced_d;
            debounced_prev_q <= debounced_q;
            stable_q         <= stable_d;
            key_code_q       <= kp.Key_code;
        end
    end

    // Rises are consumed even when suppressed, so a blocked key never fires later.
    assign rise = debounced_q & ~debounced_prev_q;
    assign fire = kp.Enable && is_onehot(rise);

    always_comb begin
        kp.Col       = ~(4'b0001 << col_q);
        kp.Hit_point = fire ? rise : '0;
        kp.Key_valid = fire;
        kp.Key_code  = fire ? onehot_index(rise) : key_code_q;
    end

endmodule

// File: tb/tb_mole_keypad_scanner.sv
// Directed bench for mole_keypad_scanner with a behavioural 4x4 key matrix.
module tb_mole_keypad_scanner;
    import mole_pkg::*;

    typedef struct {
        int         key;
        logic       en;
        logic [15:0] exp_hit;
        logic [3:0]  exp_code;
    } vec_t;

    logic        clk;
    logic        set_n;
    logic [15:0] pressed;
    logic [3:0]  row_drv;

    int tests;
    int fails;
    int cyc;

    int          pulse_total;
    int          viol;
    int          last_pulse_cyc;
    logic [15:0] last_hit;
    logic [3:0]  last_code;
    logic [15:0] prev_hit;

    vec_t vecs[5];

    mole_keypad_scanner_if kb ();

    mole_keypad_scanner #(
        .SCAN_DIV (4),
        .DEBOUNCE (3)
    ) dut (
        .Clk (clk),
        .Set (set_n),
        .kp  (kb.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // A pressed key shorts its row to the column currently driven low.
    always_comb begin
        row_drv = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!kb.Col[c] && pressed[4*r+c]) row_drv[r] = 1'b0;
            end
        end
    end
    assign kb.Row = row_drv;

    always @(negedge clk) begin
        if (!set_n) begin
            prev_hit = '0;
        end else begin
            if (kb.Key_valid || kb.Hit_point != 16'h0) begin
                pulse_total    = pulse_total + 1;
                last_pulse_cyc = cyc;
                last_hit       = kb.Hit_point;
                last_code      = kb.Key_code;
                if (!kb.Key_valid || !is_onehot(kb.Hit_point) || prev_hit != 16'h0)
                    viol = viol + 1;
            end
            prev_hit = kb.Hit_point;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Press a key, hold it, release it, and report pulses seen in that window.
    task automatic press_hold_release(input logic [15:0] keys, input int hold,
                                      output int npulse, output int latency);
        int base;
        int t0;
        base    = pulse_total;
        t0      = cyc;
        pressed = keys;
        wait_clks(hold);
        pressed = '0;
        wait_clks(80);
        npulse  = pulse_total - base;
        latency = last_pulse_cyc - t0;
    endtask

    initial begin
        int          np;
        int          lat;
        int          base;
        logic [3:0]  exp_col;

        tests = 0; fails = 0; cyc = 0;
        pulse_total = 0; viol = 0; last_pulse_cyc = 0;
        last_hit = '0; last_code = '0; prev_hit = '0;
        pressed = '0;
        kb.Enable = 1'b1;
        set_n = 1'b0;

        vecs[0] = '{key: 9,  en: 1'b1, exp_hit: 16'h0200, exp_code: 4'd9};
        vecs[1] = '{key: 0,  en: 1'b1, exp_hit: 16'h0001, exp_code: 4'd0};
        vecs[2] = '{key: 15, en: 1'b1, exp_hit: 16'h8000, exp_code: 4'd15};
        vecs[3] = '{key: 3,  en: 1'b0, exp_hit: 16'h0000, exp_code: 4'd15};
        vecs[4] = '{key: 5,  en: 1'b1, exp_hit: 16'h0020, exp_code: 4'd5};

        wait_clks(3);
        check("reset_col", 32'(kb.Col), 32'h0000000E);
        check("reset_hit", 32'(kb.Hit_point), 32'h0);
        check("reset_valid", 32'(kb.Key_valid), 32'h0);
        check("reset_code", 32'(kb.Key_code), 32'h0);

        set_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            exp_col = 4'b0001 << ((k / 4) % 4);
            exp_col = ~exp_col;
            check($sformatf("col_rotate_%0d", k), 32'(kb.Col), 32'(exp_col));
            wait_clks(1);
        end
        wait_clks(1000);
        check("idle_no_pulse", 32'(pulse_total), 32'h0);

        for (int i = 0; i < 5; i++) begin
            kb.Enable = vecs[i].en;
            press_hold_release(16'h0001 << vecs[i].key, 100, np, lat);
            check($sformatf("vec%0d_pulses", i), 32'(np), vecs[i].en ? 32'd1 : 32'd0);
            if (vecs[i].en) begin
                check($sformatf("vec%0d_hit", i), 32'(last_hit), 32'(vecs[i].exp_hit));
                check($sformatf("vec%0d_code", i), 32'(last_code), 32'(vecs[i].exp_code));
                check($sformatf("vec%0d_latency_le67", i), 32'(lat <= 67), 32'd1);
            end
            check($sformatf("vec%0d_code_hold", i), 32'(kb.Key_code), 32'(vecs[i].exp_code));
        end
        kb.Enable = 1'b1;

        // Bouncing contact on key 9, then settled closed.
        base = pulse_total;
        for (int t = 0; t < 7; t++) begin
            pressed = (t % 2 == 0) ? 16'h0200 : 16'h0000;
            wait_clks(3);
        end
        check("bounce_no_early_pulse", 32'(pulse_total - base), 32'd0);
        press_hold_release(16'h0200, 100, np, lat);
        check("bounce_pulses", 32'(pulse_total - base), 32'd1);
        check("bounce_hit", 32'(last_hit), 32'h0200);

        // Two keys together are suppressed and stay consumed.
        press_hold_release(16'h8001, 100, np, lat);
        check("ghost_no_pulse", 32'(np), 32'd0);
        press_hold_release(16'h0001, 100, np, lat);
        check("after_ghost_pulses", 32'(np), 32'd1);
        check("after_ghost_hit", 32'(last_hit), 32'h0001);

        // Enable raised while the key is already debounced-held.
        kb.Enable = 1'b0;
        base = pulse_total;
        pressed = 16'h0020;
        wait_clks(80);
        kb.Enable = 1'b1;
        wait_clks(40);
        pressed = '0;
        wait_clks(80);
        check("enable_late_no_pulse", 32'(pulse_total - base), 32'd0);
        press_hold_release(16'h0020, 100, np, lat);
        check("enable_repress_pulses", 32'(np), 32'd1);
        check("enable_repress_hit", 32'(last_hit), 32'h0020);

        // Reset mid-operation while key 3 is held.
        pressed = 16'h0008;
        wait_clks(100);
        wait_clks(5);
        #2 set_n = 1'b0;
        #1;
        check("midreset_col", 32'(kb.Col), 32'h0000000E);
        check("midreset_hit", 32'(kb.Hit_point), 32'h0);
        check("midreset_valid", 32'(kb.Key_valid), 32'h0);
        check("midreset_code", 32'(kb.Key_code), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        set_n = 1'b1;
        base = pulse_total;
        wait_clks(100);
        pressed = '0;
        wait_clks(80);
        check("postreset_pulses", 32'(pulse_total - base), 32'd1);
        check("postreset_hit", 32'(last_hit), 32'h0008);

        check("hit_protocol_violations", 32'(viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mole_keypad_scanner.md
Name: mole_keypad_scanner

Overview:
- Upstream input stage of the whack-a-mole top level. Scans a 4x4 active-low matrix keypad, synchronises and debounces it, and converts each new single-key press into a one-clock, one-hot Hit_point pulse.
- Hit_point feeds the Mole top, which forwards it to the cell/selector logic as hit_reg.
- Replaces the bench-driven Hit_point stimulus with real hardware input.

Parameters:
- SCAN_DIV, 4: clocks each column is driven before its rows are sampled; legal 2..255.
- DEBOUNCE, 3: consecutive identical scan frames required before the debounced key state changes; legal 1..15.

Ports:
- Clk  input  1  system clock; all state on rising edge.
- Set  input  1  reset; asynchronous assert, active-low, release synchronous to Clk.
- Enable  input  1  Controller's reg_enable; when 0, press pulses are discarded.
- Col  output  4  column drive, active-low, exactly one bit low at any time.
- Row  input  4  row sense, active-low (pulled up externally), asynchronous to Clk.
- Hit_point  output  16  one-hot, one-clock pulse; bit index = 4*row + col.
- Key_valid  output  1  high in the same cycle as a Hit_point pulse.
- Key_code  output  4  index of the pulsed key; holds its last value otherwise.

Behaviour:
- Reset values:
  - Col=4'b1110.
  - Hit_point=0, Key_valid=0, Key_code=0.
  - Column index, dwell counter, frame, previous-frame, debounced and stable registers all 0.
- Synchroniser: Row passes through 2 flops before use.
- Scan sequence:
  - Column index c cycles 0,1,2,3,0,...; Col = ~(1<<c).
  - The dwell counter counts 0..SCAN_DIV-1.
  - In the dwell-count == SCAN_DIV-1 cycle, the 4 inverted synchronised rows are written into frame bits {4*r+c}; c then advances and the counter clears.
  - Wrap 3 -> 0 marks frame end. A frame is 4*SCAN_DIV clocks.
- Debounce, evaluated on the frame-end cycle:
  - If frame == prev_frame: stable count increments, saturating at DEBOUNCE.
  - Otherwise: stable count resets to 1.
  - prev_frame <= frame.
  - When the stable count reaches DEBOUNCE, debounced <= frame.
  - DEBOUNCE=1: debounced follows every frame.
- Edge detect, in the cycle after the debounced update:
  - rise = debounced & ~debounced_prev.
  - Exactly one bit set in rise and Enable=1: Hit_point = rise for 1 clock, Key_valid=1, Key_code = its index.
  - Zero or more than one bit set in rise: no pulse (multi-key / ghost suppression). The debounced state is still updated, so those keys do not fire later.
  - Releases produce nothing. A held key produces one pulse only. Re-press requires a debounced release first.
- Enable=0: scanning and debounce continue and rises are consumed without a pulse. Raising Enable while a key is held does not fire that key.
- Latency: a clean press lands within one frame, then DEBOUNCE frames plus 1 clock until the pulse. Worst case is (DEBOUNCE+1)*4*SCAN_DIV+3 clocks including the synchroniser.
- Simultaneous events: a key changing during the sample cycle is caught by the synchroniser, and the debounce absorbs the ambiguity.
- Reset mid-operation: all state clears immediately. A key still held after reset release is captured as a new rise and pulses once (debounced starts at 0).
- Hit_point is never more than one-hot and never asserted for 2 consecutive clocks (minimum spacing is one frame).

Decomposition:
- Package mole_pkg:
  - constants NUM_ROWS=4, NUM_COLS=4, NUM_KEYS=16, KEY_W=4.
  - function onehot_index(16-bit) -> 4-bit.
  - function is_onehot(16-bit) -> 1-bit.
- Sub-module mole_row_sync: 4-bit, 2-flop synchroniser with async active-low clear to "no press" (4'b1111).
- Everything else (scan counter, frame/debounce, edge detect) stays in mole_keypad_scanner.

Test Plan (SCAN_DIV=4, DEBOUNCE=3, frame = 16 clocks):
- Reset, no keys -> Col rotates 1110,1101,1011,0111 every 4 clocks; Hit_point stays 0 for 1000 clocks.
- Hold key r=2,c=1 for 100 clocks with Enable=1 -> exactly one pulse, Hit_point=16'h0200, Key_code=9, Key_valid=1 for 1 clock, within 67 clocks of the press.
- Press key 9 with a bounce (toggle every 3 clocks for 20 clocks, then stable) -> exactly one pulse, no pulse during the bounce.
- Press keys 0 and 15 in the same frame and hold -> no pulse. Release both, then press key 0 alone -> Hit_point=16'h0001.
- Enable=0, press key 5, raise Enable while still held -> no pulse. Release, re-press key 5 -> Hit_point=16'h0020.
- Hold key 3, assert Set for 2 clocks mid-frame -> outputs return to reset values immediately; after release, key 3 pulses exactly once (Hit_point=16'h0008).
